// File: rtl/imager_capture_sequencer_if.sv
// Camera-side handshake bundle between the capture sequencer and its stonyman controllers.
interface imager_capture_sequencer_if #(
    parameter int NUM_CAMS = 2
);
    logic [NUM_CAMS-1:0] frame_capture_start;
    logic [NUM_CAMS-1:0] frame_capture_done;
    logic [NUM_CAMS-1:0] cam_reset;

    modport master (
        output frame_capture_start,
        output cam_reset,
        input  frame_capture_done
    );

    modport slave (
        input  frame_capture_start,
        input  cam_reset,
        output frame_capture_done
    );
endinterface

// File: rtl/imager_capture_sequencer.sv
// Frame-capture scheduler for NUM_CAMS stonyman channels (sequential or simultaneous, with per-capture timeout).
// Optional macro CAPTURE_LATENCY_EN: when defined, last_latency reports start-to-done cycles of the last capture.
module imager_capture_sequencer #(
    parameter int NUM_CAMS  = 2,
    parameter int PERIOD_W  = 24,
    parameter int TIMEOUT_W = 24,
    parameter int CNT_W     = 16,
    localparam int AW       = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [NUM_CAMS-1:0]       cam_mask,
    input  logic [PERIOD_W-1:0]       period,
    input  logic [TIMEOUT_W-1:0]      timeout,
    input  logic                      clear_flags,
    imager_capture_sequencer_if.master cam,
    output logic [NUM_CAMS-1:0]       timeout_flags,
    output logic                      seq_done,
    output logic                      busy,
    output logic [AW-1:0]             active_cam,
    output logic [CNT_W-1:0]          seq_count,
    output logic [TIMEOUT_W-1:0]      last_latency
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        RECOVER,
        WAIT_PERIOD
    } state_t;

    localparam logic [TIMEOUT_W:0] TIMEOUT_ONE = 1;
    localparam logic [PERIOD_W:0]  PERIOD_ONE  = 1;

    state_t                state, state_n;
    logic [NUM_CAMS-1:0]   mask_q, mask_n;
    logic                  mode_q, mode_n;
    logic [NUM_CAMS-1:0]   pending, pending_n;
    logic [AW-1:0]         active_q, active_n;
    logic [TIMEOUT_W-1:0]  tcount;
    logic [PERIOD_W-1:0]   pcount;
    logic                  seq_start;
    logic                  seq_end;

    logic [NUM_CAMS-1:0]   active_bit;
    logic [NUM_CAMS-1:0]   accepted;
    logic [NUM_CAMS-1:0]   remaining;
    logic [NUM_CAMS-1:0]   recover_set;
    logic [NUM_CAMS-1:0]   rec_remaining;
    logic                  expired;
    logic                  period_reached;

    function automatic logic [AW-1:0] lowest_index(input logic [NUM_CAMS-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = NUM_CAMS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    // Done pulses count only on pending channels, and only on the active one in sequential mode.
    assign active_bit    = NUM_CAMS'(1) << active_q;
    assign accepted      = cam.frame_capture_done & pending & (mode_q ? {NUM_CAMS{1'b1}} : active_bit);
    assign remaining     = pending & ~accepted;
    assign recover_set   = mode_q ? pending : (pending & active_bit);
    assign rec_remaining = pending & ~recover_set;

    // Both counters read 0 in the START cycle, so comparing count+1 fires exactly N cycles after the start pulse.
    assign expired        = (timeout != '0) && (({1'b0, tcount} + TIMEOUT_ONE) >= {1'b0, timeout});
    assign period_reached = (({1'b0, pcount} + PERIOD_ONE) >= {1'b0, period});

    always_comb begin
        state_n   = state;
        mask_n    = mask_q;
        mode_n    = mode_q;
        pending_n = pending;
        active_n  = active_q;
        seq_start = 1'b0;
        seq_end   = 1'b0;

        case (state)
            IDLE: begin
                if (enable && (cam_mask != '0)) begin
                    seq_start = 1'b1;
                end
            end
            START: begin
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (accepted != '0) begin
                    pending_n = remaining;
                    if (remaining == '0) begin
                        seq_end = 1'b1;
                    end else if (!mode_q) begin
                        active_n = lowest_index(remaining);
                        state_n  = START;
                    end
                end else if (expired) begin
                    state_n = RECOVER;
                end
            end
            RECOVER: begin
                pending_n = rec_remaining;
                if (rec_remaining == '0) begin
                    seq_end = 1'b1;
                end else begin
                    active_n = lowest_index(rec_remaining);
                    state_n  = START;
                end
            end
            WAIT_PERIOD: begin
                if (period_reached) begin
                    if (enable && (cam_mask != '0)) begin
                        seq_start = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (seq_start) begin
            state_n   = START;
            mask_n    = cam_mask;
            mode_n    = mode;
            pending_n = cam_mask;
            active_n  = lowest_index(cam_mask);
        end
        if (seq_end) begin
            state_n = WAIT_PERIOD;
        end
    end

    // Period counter restarts only at a sequence start so the period spans whole sequences.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            mask_q        <= '0;
            mode_q        <= 1'b0;
            pending       <= '0;
            active_q      <= '0;
            tcount        <= '0;
            pcount        <= '0;
            timeout_flags <= '0;
            seq_done      <= 1'b0;
            seq_count     <= '0;
        end else begin
            state    <= state_n;
            mask_q   <= mask_n;
            mode_q   <= mode_n;
            pending  <= pending_n;
            active_q <= active_n;
            seq_done <= seq_end;

            if (state_n == START) begin
                tcount <= '0;
            end else if (((state == START) || (state == WAIT_DONE)) && (tcount != '1)) begin
                tcount <= tcount + TIMEOUT_W'(1);
            end

            if (seq_start) begin
                pcount <= '0;
            end else if (pcount != '1) begin
                pcount <= pcount + PERIOD_W'(1);
            end

            timeout_flags <= (timeout_flags & ~{NUM_CAMS{clear_flags}})
                           | ((state == RECOVER) ? recover_set : '0);

            if (seq_end) begin
                seq_count <= seq_count + CNT_W'(1);
            end
        end
    end

`ifdef CAPTURE_LATENCY_EN
    logic latency_load;

    // Simultaneous mode keeps only the latency of the final done of the sequence.
    assign latency_load = (state == WAIT_DONE) && (accepted != '0) && (!mode_q || (remaining == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_latency <= '0;
        end else if (latency_load) begin
            last_latency <= tcount;
        end
    end
`else
    assign last_latency = '0;
`endif

    assign cam.frame_capture_start = (state == START) ? (mode_q ? mask_q : active_bit) : '0;
    assign cam.cam_reset           = (state == RECOVER) ? recover_set : '0;
    assign busy                    = (state != IDLE);
    assign active_cam              = mode_q ? '0 : active_q;

endmodule

// File: tb/tb_imager_capture_sequencer.sv
// Directed self-checking bench for imager_capture_sequencer with NUM_CAMS=2.
module tb_imager_capture_sequencer;

    localparam int NUM_CAMS  = 2;
    localparam int PERIOD_W  = 24;
    localparam int TIMEOUT_W = 24;
    localparam int CNT_W     = 16;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 mode;
    logic [NUM_CAMS-1:0]  cam_mask;
    logic [PERIOD_W-1:0]  period;
    logic [TIMEOUT_W-1:0] timeout;
    logic                 clear_flags;
    logic [NUM_CAMS-1:0]  timeout_flags;
    logic                 seq_done;
    logic                 busy;
    logic [0:0]           active_cam;
    logic [CNT_W-1:0]     seq_count;
    logic [TIMEOUT_W-1:0] last_latency;

    imager_capture_sequencer_if #(.NUM_CAMS(NUM_CAMS)) cam();

    imager_capture_sequencer #(
        .NUM_CAMS (NUM_CAMS),
        .PERIOD_W (PERIOD_W),
        .TIMEOUT_W(TIMEOUT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .cam_mask     (cam_mask),
        .period       (period),
        .timeout      (timeout),
        .clear_flags  (clear_flags),
        .cam          (cam),
        .timeout_flags(timeout_flags),
        .seq_done     (seq_done),
        .busy         (busy),
        .active_cam   (active_cam),
        .seq_count    (seq_count),
        .last_latency (last_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] mask;
        logic [1:0] exp_start;
        logic       exp_active;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[6];
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   start_cnt[2];
    int   reset_cnt;
    int   start0_snapshot;
    int   exp_latency;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_CAMS; i++) begin
            if (cam.frame_capture_start[i]) begin
                start_cnt[i]++;
            end
        end
        if (cam.cam_reset != '0) begin
            reset_cnt++;
        end
    endtask

    task automatic pulse_done(input logic [1:0] d);
        cam.frame_capture_done = d;
        step();
        cam.frame_capture_done = '0;
    endtask

    task automatic apply_stimulus(input logic m, input logic [1:0] mask, input logic [23:0] per, input logic [23:0] tmo);
        mode     = m;
        cam_mask = mask;
        period   = per;
        timeout  = tmo;
        enable   = 1'b1;
    endtask

    task automatic do_reset();
        reset                  = 1'b0;
        enable                 = 1'b0;
        mode                   = 1'b0;
        cam_mask               = '0;
        period                 = '0;
        timeout                = '0;
        clear_flags            = 1'b0;
        cam.frame_capture_done = '0;
        step();
        step();
        reset        = 1'b1;
        cyc          = 0;
        start_cnt[0] = 0;
        start_cnt[1] = 0;
        reset_cnt    = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 2'b11, 2'b01, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

        do_reset();
        check_output("reset_busy", busy, 0);
        check_output("reset_start", cam.frame_capture_start, 0);
        check_output("reset_seq_count", seq_count, 0);
        check_output("reset_flags", timeout_flags, 0);

        // First cycle after an IDLE start for each mode/mask combination.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            apply_stimulus(vecs[v].mode, vecs[v].mask, 24'd0, 24'd0);
            step();
            check_output($sformatf("vec%0d_start", v), cam.frame_capture_start, vecs[v].exp_start);
            check_output($sformatf("vec%0d_active", v), active_cam, vecs[v].exp_active);
            check_output($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
        end

        // Sequential, both cameras, done 10 cycles after each start; enable dropped mid-sequence.
        do_reset();
        apply_stimulus(1'b0, 2'b11, 24'd0, 24'd0);
        step();
        check_output("seq_c1_start", cam.frame_capture_start, 2'b01);
        enable = 1'b0;
        repeat (10) step();
        pulse_done(2'b01);
        check_output("seq_c12_start", cam.frame_capture_start, 2'b10);
        check_output("seq_c12_active", active_cam, 1);
        repeat (10) step();
        pulse_done(2'b10);
        check_output("seq_c23_done", seq_done, 1);
        check_output("seq_c23_count", seq_count, 1);
        check_output("seq_starts0", start_cnt[0], 1);
        check_output("seq_starts1", start_cnt[1], 1);
        step();
        check_output("seq_c24_idle", busy, 0);

        // Sequential with only camera 1 enabled.
        do_reset();
        apply_stimulus(1'b0, 2'b10, 24'd0, 24'd0);
        step();
        enable = 1'b0;
        repeat (2) step();
        pulse_done(2'b10);
        check_output("mask10_done", seq_done, 1);
        check_output("mask10_starts0", start_cnt[0], 0);
        check_output("mask10_starts1", start_cnt[1], 1);

        // Simultaneous, done[1] at +5 and done[0] at +9.
        do_reset();
        apply_stimulus(1'b1, 2'b11, 24'd0, 24'd0);
        step();
        enable = 1'b0;
        repeat (5) step();
        pulse_done(2'b10);
        check_output("sim_partial_busy", busy, 1);
        check_output("sim_partial_done", seq_done, 0);
        repeat (3) step();
        pulse_done(2'b01);
        check_output("sim_done", seq_done, 1);
`ifdef CAPTURE_LATENCY_EN
        exp_latency = 9;
`else
        exp_latency = 0;
`endif
        check_output("sim_latency", last_latency, exp_latency);
        check_output("sim_starts0", start_cnt[0], 1);
        check_output("sim_starts1", start_cnt[1], 1);

        // Timeout on camera 0, then flag clear.
        do_reset();
        apply_stimulus(1'b0, 2'b11, 24'd0, 24'd20);
        step();
        enable = 1'b0;
        repeat (19) step();
        check_output("tmo_c20_no_reset", cam.cam_reset, 0);
        step();
        check_output("tmo_c21_reset", cam.cam_reset, 2'b01);
        step();
        check_output("tmo_c22_start", cam.frame_capture_start, 2'b10);
        check_output("tmo_c22_flags", timeout_flags, 2'b01);
        repeat (2) step();
        pulse_done(2'b10);
        check_output("tmo_seq_done", seq_done, 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check_output("tmo_cleared", timeout_flags, 0);
        check_output("tmo_reset_pulses", reset_cnt, 1);

        // Period 100 with done landing on the timeout-expiry cycle.
        do_reset();
        apply_stimulus(1'b0, 2'b01, 24'd100, 24'd11);
        step();
        repeat (10) step();
        pulse_done(2'b01);
        check_output("per_seq_done", seq_done, 1);
        repeat (88) step();
        check_output("per_c100_starts", start_cnt[0], 1);
        step();
        check_output("per_c101_start", cam.frame_capture_start, 2'b01);
        enable = 1'b0;
        repeat (10) step();
        pulse_done(2'b01);
        check_output("per_no_cam_reset", reset_cnt, 0);
        check_output("per_seq_count", seq_count, 2);
        for (int i = 0; i < 300 && busy; i++) begin
            step();
        end
        check_output("per_idle_cycle", cyc, 201);

        // Reset in the middle of WAIT_DONE.
        apply_stimulus(1'b0, 2'b11, 24'd0, 24'd0);
        step();
        check_output("rst_pre_start", cam.frame_capture_start, 2'b01);
        repeat (3) step();
        reset = 1'b0;
        step();
        check_output("rst_busy", busy, 0);
        check_output("rst_start", cam.frame_capture_start, 0);
        check_output("rst_seq_count", seq_count, 0);
        check_output("rst_seq_done", seq_done, 0);
        reset  = 1'b1;
        enable = 1'b0;
        start0_snapshot = start_cnt[0];
        repeat (5) step();
        check_output("rst_no_start", start_cnt[0], start0_snapshot);
        enable = 1'b1;
        step();
        check_output("rst_restart", cam.frame_capture_start, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
